// File: rtl/move_input_arbiter.sv
// Button conditioner and fixed-priority move arbiter for the Tetris CPU (clk25 domain).
// Optional MOVE_ARB_DROP_CNT_EN adds drop_count, a saturating count of coalesced events.
module move_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1250000,
  parameter int CNT_W           = 24,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic warmDone,
  output logic level,
  output logic evt
);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic             meta, sync, deb, armed, flip, repEv;
  logic [CNT_W-1:0] dcnt, rcnt;

  assign flip  = (sync != deb) && (dcnt == DB_LAST);
  assign repEv = REPEAT_EN && deb && !flip && (rcnt == RD_LAST);
  // A button held through reset stays unarmed until it is seen released.
  assign evt   = armed && ((flip && sync) || repEv);
  assign level = deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      armed <= 1'b0;
      dcnt  <= '0;
      rcnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (warmDone && !deb && !sync) armed <= 1'b1;
      if (sync == deb) dcnt <= '0;
      else if (flip) begin
        deb  <= sync;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
      if (!deb || flip)        rcnt <= '0;
      else if (rcnt == RD_LAST) rcnt <= RP_RELOAD;
      else                     rcnt <= rcnt + 1'b1;
    end
  end
endmodule

module move_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1250000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_rotate,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       move_rotate,
  output logic [3:0] held
`ifdef MOVE_ARB_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);
  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t               state;
  logic [NUM_BTN-1:0]   raw, evt, pending, sel, cmd, clr;
  logic [1:0]           warm;
  logic                 warmDone, cmdValid;

  assign raw      = {btn_rotate, btn_down, btn_right, btn_left};
  assign warmDone = &warm;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    move_btn_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W),
      .REPEAT_EN      (i != 3)
    ) u_cond (
      .clk     (clk),
      .reset   (reset),
      .raw     (raw[i]),
      .warmDone(warmDone),
      .level   (held[i]),
      .evt     (evt[i])
    );
  end

  // Priority rotate > down > left > right.
  always_comb begin
    sel = '0;
    if      (pending[3]) sel[3] = 1'b1;
    else if (pending[2]) sel[2] = 1'b1;
    else if (pending[0]) sel[0] = 1'b1;
    else if (pending[1]) sel[1] = 1'b1;
  end

  assign clr = (state == ISSUE && cmd_ack) ? cmd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      warm     <= '0;
      pending  <= '0;
      cmd      <= '0;
      cmdValid <= 1'b0;
    end else begin
      if (!warmDone) warm <= warm + 1'b1;
      // An event landing on the ack edge re-arms the bit being cleared.
      pending <= (pending & ~clr) | evt;
      case (state)
        IDLE: if (|pending) begin
          cmd      <= sel;
          cmdValid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (cmd_ack) begin
          cmd      <= '0;
          cmdValid <= 1'b0;
          state    <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MOVE_ARB_DROP_CNT_EN
  logic [NUM_BTN-1:0] drop;
  logic [2:0]         nDrop;
  logic [8:0]         dropSum;

  always_comb begin
    drop  = evt & pending & ~clr;
    nDrop = '0;
    for (int i = 0; i < NUM_BTN; i++) nDrop = nDrop + 3'(drop[i]);
    dropSum = {1'b0, drop_count} + 9'(nDrop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               drop_count <= '0;
    else if (dropSum > 9'd255) drop_count <= 8'd255;
    else                     drop_count <= dropSum[7:0];
  end
`endif

  assign cmd_valid   = cmdValid;
  assign move_left   = cmd[0];
  assign move_right  = cmd[1];
  assign move_down   = cmd[2];
  assign move_rotate = cmd[3];
endmodule

// File: tb/tb_move_input_arbiter.sv
// Directed bench for move_input_arbiter with short debounce/repeat timing.
module tb_move_input_arbiter;
  logic clk = 1'b0;
  logic reset, btn_left, btn_right, btn_down, btn_rotate, cmd_ack;
  logic cmd_valid, move_left, move_right, move_down, move_rotate;
  logic [3:0] held, moves;
`ifdef MOVE_ARB_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  int nVec = 0;
  int nErr = 0;

  assign moves = {move_rotate, move_down, move_right, move_left};

  move_input_arbiter #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_rotate(btn_rotate),
    .cmd_ack(cmd_ack), .cmd_valid(cmd_valid),
    .move_left(move_left), .move_right(move_right), .move_down(move_down), .move_rotate(move_rotate),
    .held(held)
`ifdef MOVE_ARB_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0; cmd_ack = 1'b1;
    idle(3);
    nVec++;
    if ({cmd_valid, moves, held} !== 9'b0) begin
      nErr++;
      $display("FAIL reset_state: got valid=%b moves=%b held=%b, want all 0", cmd_valid, moves, held);
    end
    reset = 1'b0;
    idle(10);
  endtask

  task automatic test_single_press();
    btn_left = 1'b1;
    idle(6);
    nVec++;
    if (cmd_valid !== 1'b0) begin
      nErr++; $display("FAIL single_early: valid=%b after edge 6, want 0", cmd_valid);
    end
    step();
    nVec++;
    if ({cmd_valid, moves} !== 5'b1_0001) begin
      nErr++; $display("FAIL single_issue: valid/moves=%b after edge 7, want 10001", {cmd_valid, moves});
    end
    nVec++;
    if (held[0] !== 1'b1) begin
      nErr++; $display("FAIL single_held: held=%b, want bit0 set", held);
    end
    step();
    nVec++;
    if ({cmd_valid, moves} !== 5'b0) begin
      nErr++; $display("FAIL single_gap: valid/moves=%b after edge 8, want 00000", {cmd_valid, moves});
    end
    btn_left = 1'b0;
    idle(20);
  endtask

  task automatic test_glitch();
    int nCmd = 0;
    logic sawHeld = 1'b0;
    btn_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nCmd += int'(cmd_valid);
      sawHeld |= held[1];
    end
    btn_right = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      nCmd += int'(cmd_valid);
      sawHeld |= held[1];
    end
    nVec++;
    if (nCmd != 0) begin
      nErr++; $display("FAIL glitch_cmd: %0d valid cycles, want 0", nCmd);
    end
    nVec++;
    if (sawHeld !== 1'b0) begin
      nErr++; $display("FAIL glitch_held: held[1] went %b, want 0", sawHeld);
    end
  endtask

  task automatic test_repeat();
    int expEdge[4] = '{7, 27, 35, 43};
    int gotEdge[4] = '{-1, -1, -1, -1};
    int nCmd = 0;
    int badMove = 0;
    logic prevValid = 1'b0;
    btn_down = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      step();
      if (cmd_valid && !prevValid) begin
        if (nCmd < 4) gotEdge[nCmd] = e;
        nCmd++;
      end
      if (cmd_valid && moves !== 4'b0100) badMove++;
      prevValid = cmd_valid;
      if (e == 40) btn_down = 1'b0;
    end
    nVec++;
    if (nCmd != 4) begin
      nErr++; $display("FAIL repeat_count: %0d commands, want 4", nCmd);
    end
    for (int k = 0; k < 4; k++) begin
      nVec++;
      if (gotEdge[k] != expEdge[k]) begin
        nErr++; $display("FAIL repeat_time%0d: edge %0d, want %0d", k, gotEdge[k], expEdge[k]);
      end
    end
    nVec++;
    if (badMove != 0) begin
      nErr++; $display("FAIL repeat_move: %0d cycles not move_down, want 0", badMove);
    end
  endtask

  task automatic test_simultaneous();
    btn_left = 1'b1; btn_rotate = 1'b1;
    idle(7);
    nVec++;
    if ({cmd_valid, moves} !== 5'b1_1000) begin
      nErr++; $display("FAIL simul_first: valid/moves=%b, want 11000", {cmd_valid, moves});
    end
    step();
    nVec++;
    if ({cmd_valid, moves} !== 5'b0) begin
      nErr++; $display("FAIL simul_gap1: valid/moves=%b, want 00000", {cmd_valid, moves});
    end
    step();
    nVec++;
    if ({cmd_valid, moves} !== 5'b0) begin
      nErr++; $display("FAIL simul_gap2: valid/moves=%b, want 00000", {cmd_valid, moves});
    end
    step();
    nVec++;
    if ({cmd_valid, moves} !== 5'b1_0001) begin
      nErr++; $display("FAIL simul_second: valid/moves=%b, want 10001", {cmd_valid, moves});
    end
    btn_left = 1'b0; btn_rotate = 1'b0;
    idle(20);
  endtask

  task automatic test_ack_stall();
    int unstable = 0;
    int extra = 0;
    cmd_ack = 1'b0;
    btn_down = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      step();
      if (e >= 7 && {cmd_valid, moves} !== 5'b1_0100) unstable++;
      if (e == 40) btn_down = 1'b0;
    end
    nVec++;
    if (unstable != 0) begin
      nErr++; $display("FAIL stall_stable: %0d unstable cycles, want 0", unstable);
    end
    cmd_ack = 1'b1;
    step();
    nVec++;
    if (cmd_valid !== 1'b0) begin
      nErr++; $display("FAIL stall_ack: valid=%b after ack edge, want 0", cmd_valid);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      extra += int'(cmd_valid);
    end
    nVec++;
    if (extra != 0) begin
      nErr++; $display("FAIL stall_extra: %0d extra valid cycles, want 0", extra);
    end
`ifdef MOVE_ARB_DROP_CNT_EN
    nVec++;
    if (drop_count !== 8'd3) begin
      nErr++; $display("FAIL stall_drops: drop_count=%0d, want 3", drop_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int nCmd = 0;
    cmd_ack = 1'b0;
    btn_left = 1'b1;
    idle(7);
    nVec++;
    if ({cmd_valid, moves} !== 5'b1_0001) begin
      nErr++; $display("FAIL rstmid_pre: valid/moves=%b, want 10001", {cmd_valid, moves});
    end
    #2 reset = 1'b1;
    #1;
    nVec++;
    if ({cmd_valid, moves} !== 5'b0) begin
      nErr++; $display("FAIL rstmid_async: valid/moves=%b, want 00000", {cmd_valid, moves});
    end
    step();
    reset = 1'b0;
    cmd_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      nCmd += int'(cmd_valid);
    end
    nVec++;
    if (nCmd != 0) begin
      nErr++; $display("FAIL rstmid_held: %0d valid cycles while held, want 0", nCmd);
    end
    nVec++;
    if (held[0] !== 1'b1) begin
      nErr++; $display("FAIL rstmid_level: held=%b, want bit0 set", held);
    end
    btn_left = 1'b0;
    idle(15);
    btn_left = 1'b1;
    idle(7);
    nVec++;
    if ({cmd_valid, moves} !== 5'b1_0001) begin
      nErr++; $display("FAIL rstmid_repress: valid/moves=%b, want 10001", {cmd_valid, moves});
    end
    btn_left = 1'b0;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_ack_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
